ifmap_stream_feeder: RTL
========================

# ifmap_stream_feeder

Input-feature-map source for the convolution controller. A host loads one frame of feature bytes into an on-chip buffer through a byte-wide write port. The block packs the bytes into 64-bit words and raises `start_conv`. It then serves the controller's `read_I` requests, returning one 64-bit `Idata` word per request, and pulses `frame_done` once the whole frame has been consumed.

## Interface
Parameters:
- `DEPTH`, default 64: buffer capacity in 64-bit words. Must be a power of two, ≥ 2.
- `ADDR_W`, default 6: log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `frame_start`  in  1  one-cycle pulse that starts a frame; sampled only in IDLE.
- `cfg_words`  in  `ADDR_W`+1  frame length in 64-bit words, valid range 1..`DEPTH`; latched on an accepted `frame_start`.
- `wr_en`  in  1  host byte-write strobe.
- `wr_byte`  in  8  host data byte.
- `wr_ready`  out  1  block can accept a byte; high only in FILL.
- `start_conv`  out  1  level signal, high throughout STREAM.
- `read_I`  in  1  controller read request, one word per cycle it is high.
- `Idata`  out  64  returned word.
- `Idata_valid`  out  1  `Idata` is valid this cycle.
- `frame_done`  out  1  one-cycle pulse when the frame has been fully read.

## Operation
- States are IDLE, FILL, STREAM and DONE. All outputs are registered or decoded from the state register.
- IDLE:
  - `frame_start`=1 with 1 ≤ `cfg_words` ≤ `DEPTH` latches `cfg_words` into `len`, clears the byte, write and read counters, and moves to FILL.
  - `cfg_words`=0 or `cfg_words` > `DEPTH` is ignored; the block stays in IDLE.
- FILL:
  - A byte is accepted when `wr_en`=1 and `wr_ready`=1.
  - Byte k (0..7) of a word lands in bits [8k+7:8k], so packing is little-endian.
  - On the 8th byte the packed word is written to `buf[wr_ptr]` and `wr_ptr` increments.
  - When `wr_ptr` reaches `len`, the block moves to STREAM.
  - `read_I` is ignored in FILL.
- STREAM:
  - `read_I`=1 returns `buf[rd_ptr]` on `Idata` and increments `rd_ptr`.
  - When the accepted read is read number `len`, the block moves to DONE.
  - `wr_en` is ignored, since `wr_ready`=0.
  - `read_I` is never honoured beyond `len` reads.
- DONE: `frame_done`=1 for exactly one cycle, then the block returns to IDLE unconditionally.
- `frame_start` outside IDLE is ignored.
- `Idata` holds its last value when `Idata_valid`=0.
- Reset:
  - State goes to IDLE; all counters and pointers are 0.
  - `wr_ready`, `start_conv`, `Idata_valid` and `frame_done` are 0, and `Idata` is 64'h0.
  - Buffer contents are not cleared.
  - Reset in any state aborts the frame. A new `frame_start` after reset behaves normally.
- Counter widths: the byte counter is 3 bits and wraps 7→0 on a word push. `wr_ptr` and `rd_ptr` are `ADDR_W`+1 bits so that a value equal to `DEPTH` is representable.

## Timing
- IDLE→FILL: on the edge that samples `frame_start`. `wr_ready`=1 from the next cycle.
- FILL→STREAM: on the edge accepting the final byte. `wr_ready` drops and `start_conv` rises in the next cycle.
- Read latency is 1 cycle. For `read_I` sampled at edge N, `Idata` and `Idata_valid`=1 are visible after edge N and held until edge N+1.
- Back-to-back `read_I` gives 1 word per cycle. Gaps in `read_I` give `Idata_valid`=0 in the corresponding cycles.
- The last read: its data appears in the same cycle as DONE, with `frame_done`=1, and `start_conv` falls in that cycle.
- IDLE is reached one cycle later, so the minimum gap between `frame_done` and the next accepted `frame_start` is 1 cycle.
- Fill throughput is 1 byte per cycle, so a full frame takes 8·`len` accepted writes.

## Test plan
- **Reset values:** assert `rst` mid-cycle (asynchronous) → all outputs 0 immediately, and `Idata`=0.
- **Basic two-word frame:** `frame_start` with `cfg_words`=2, then write bytes 0x00..0x0F on consecutive cycles → `start_conv`=1 after the 16th byte. Then apply `read_I` for 2 cycles → `Idata`=64'h0706050403020100 followed by 64'h0F0E0D0C0B0A0908, `Idata_valid` high for those 2 cycles, and `frame_done` pulsing with the second word. IDLE follows.
- **Ignored inputs:**
  - `wr_en` held in IDLE and STREAM → no writes.
  - `read_I` in FILL → `Idata_valid` stays 0.
  - `frame_start` in STREAM → no effect.
  - `cfg_words`=0 or 65 → stays IDLE.
- **Full buffer:** `cfg_words`=64 with 512 random bytes, then reads with random gaps → all 64 words match in order, `Idata_valid` count is 64, and exactly one `frame_done`.
- **Reset mid-stream:** reset after 1 of 4 reads → IDLE, `start_conv`=0. A new 1-word frame of bytes 0xA0..0xA7 then reads back 64'hA7A6A5A4A3A2A1A0.
- **Back-to-back frames:** issue `frame_start` one cycle after `frame_done` → the frame is accepted and the second frame's data is correct.

Source files
------------

// File: rtl/ifmap_stream_feeder.sv
// Input-feature-map source: packs host bytes into 64-bit buffer words, then streams them
// to the convolution controller one word per read request.
module ifmap_stream_feeder #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ADDR_W:0]   cfg_words,
    input  logic              wr_en,
    input  logic [7:0]        wr_byte,
    output logic              wr_ready,
    output logic              start_conv,
    input  logic              read_I,
    output logic [63:0]       Idata,
    output logic              Idata_valid,
    output logic              frame_done
);

    typedef enum logic [1:0] {StIdle, StFill, StStream, StDone} state_e;

    localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [55:0]       pack_q, pack_d;
    logic [63:0]       idata_q, idata_d;
    logic              idata_valid_q, idata_valid_d;

    logic [63:0]       mem_q [DEPTH];
    logic              mem_we;
    logic [63:0]       mem_wdata;
    logic [ADDR_W-1:0] mem_waddr;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        byte_cnt_d    = byte_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pack_d        = pack_q;
        idata_d       = idata_q;
        idata_valid_d = 1'b0;
        mem_we        = 1'b0;
        // The eighth byte goes straight into the top lane; only bytes 0..6 are staged.
        mem_wdata     = {wr_byte, pack_q};
        mem_waddr     = wr_ptr_q[ADDR_W-1:0];

        unique case (state_q)
            StIdle: begin
                if (frame_start && (cfg_words != '0) && (cfg_words <= DepthW)) begin
                    len_d      = cfg_words;
                    byte_cnt_d = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (wr_en) begin
                    if (byte_cnt_q == 3'd7) begin
                        mem_we     = 1'b1;
                        byte_cnt_d = '0;
                        wr_ptr_d   = wr_ptr_q + PtrOne;
                        if (wr_ptr_d == len_q) begin
                            state_d = StStream;
                        end
                    end else begin
                        pack_d[{byte_cnt_q, 3'b000} +: 8] = wr_byte;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            StStream: begin
                if (read_I) begin
                    idata_d       = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    idata_valid_d = 1'b1;
                    rd_ptr_d      = rd_ptr_q + PtrOne;
                    if (rd_ptr_d == len_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pack_q        <= '0;
            idata_q       <= '0;
            idata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            byte_cnt_q    <= byte_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pack_q        <= pack_d;
            idata_q       <= idata_d;
            idata_valid_q <= idata_valid_d;
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign wr_ready    = (state_q == StFill);
    assign start_conv  = (state_q == StStream);
    assign frame_done  = (state_q == StDone);
    assign Idata       = idata_q;
    assign Idata_valid = idata_valid_q;

endmodule
